// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: requester indices, FSM states,
// and a small modulo-3 helper used by the round-robin picker.
// No ports; imported by mem_bus_arbiter and mem_bus_arbiter_rr_pick3.
package mem_bus_arbiter_pkg;

   localparam int NUM_REQ = 3;

   // Requester port indices
   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] DATA  = 2'd1;
   localparam logic [1:0] STACK = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // (a + b) mod 3 for a in 0..2 and b in 0..3; the sum never exceeds 5,
   // so a single conditional subtract is enough.
   function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 3'd3) begin
         s = s - 3'd3;
      end
      return s[1:0];
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick3.sv
// Round-robin picker for three requesters; purely combinational (0 cycles).
// No backpressure: reports the winner among asserted requests, scanning
// last_gnt+1, last_gnt+2, last_gnt (mod 3).
// Ports: i_req[2:0] requests, i_last_gnt previous winner index,
//        o_win one-hot winner, o_win_idx winner index, o_any any request set.
module mem_bus_arbiter_rr_pick3
   import mem_bus_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [1:0]         i_last_gnt,
   output logic [NUM_REQ-1:0] o_win,
   output logic [1:0]         o_win_idx,
   output logic               o_any
);

   logic [1:0] w_cand;

   always_comb begin
      o_win_idx = FETCH;
      o_any     = 1'b0;
      w_cand    = FETCH;
      // Scan from lowest to highest priority so the highest-priority
      // requester is the last one written.
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = mod3_add(i_last_gnt, 2'(k));
         if (i_req[w_cand]) begin
            o_win_idx = w_cand;
            o_any     = 1'b1;
         end
      end
      o_win = o_any ? (NUM_REQ'(1) << o_win_idx) : '0;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory between fetch, data and stack requesters.
// Latency: request sampled at edge N -> ack during the cycle after edge N+MEM_LAT.
// Backpressure: losers simply wait in IDLE; one transaction per MEM_LAT+2 cycles.
// Ports: clk/reset; i_req/i_we/i_addr/i_wdata per requester (port i at [i*W +: W]);
//        o_gnt (held ACCESS..RESP), o_ack/o_err (one-cycle), o_rdata, o_busy;
//        o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata to memory, i_mem_rdata from memory.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int              ADDR_W      = 32,
   parameter int              DATA_W      = 32,
   parameter int              MEM_LAT     = 2,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = 32'h20008C78
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [NUM_REQ-1:0]         i_we,
   input  logic [NUM_REQ*ADDR_W-1:0]  i_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  i_wdata,
   output logic [NUM_REQ-1:0]         o_gnt,
   output logic [NUM_REQ-1:0]         o_ack,
   output logic                       o_err,
   output logic [DATA_W-1:0]          o_rdata,
   output logic                       o_busy,
   output logic                       o_mem_en,
   output logic                       o_mem_we,
   output logic [ADDR_W-1:0]          o_mem_addr,
   output logic [DATA_W-1:0]          o_mem_wdata,
   input  logic [DATA_W-1:0]          i_mem_rdata
);

   localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [1:0]          r_last_gnt;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [NUM_REQ-1:0]  r_ack;
   logic                r_err;
   logic                r_busy;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [DATA_W-1:0]   r_rdata;

   logic [NUM_REQ-1:0]  w_win;
   logic [1:0]          w_win_idx;
   logic                w_any;
   logic                w_sel_we;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;
   logic                w_refuse;

   mem_bus_arbiter_rr_pick3 u_pick (
      .i_req      (i_req),
      .i_last_gnt (r_last_gnt),
      .o_win      (w_win),
      .o_win_idx  (w_win_idx),
      .o_any      (w_any)
   );

   assign w_sel_we    = i_we[w_win_idx];
   assign w_sel_addr  = i_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
   assign w_sel_wdata = i_wdata[int'(w_win_idx)*DATA_W +: DATA_W];

   // Overflow guard: only a stack-port write to the limit is refused.
   assign w_refuse = (w_win_idx == STACK) && w_sel_we && (w_sel_addr == STACK_LIMIT);

   // The memory-side registers double as the request latch: they are loaded
   // on the grant edge and held until the next grant, so later changes on the
   // requester inputs cannot disturb an access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_last_gnt  <= STACK;
         r_gnt       <= '0;
         r_ack       <= '0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         // ack/err are single-cycle pulses
         r_ack <= '0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_last_gnt <= w_win_idx;
                  r_gnt      <= w_win;
                  r_busy     <= 1'b1;
                  if (w_refuse) begin
                     // Refused write goes straight to the response cycle.
                     r_state <= ST_RESP;
                     r_ack   <= w_win;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= ST_ACCESS;
                     r_cnt       <= CNT_INIT;
                     r_mem_en    <= 1'b1;
                     r_mem_we    <= w_sel_we;
                     r_mem_addr  <= w_sel_addr;
                     r_mem_wdata <= w_sel_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               if (r_cnt == '0) begin
                  if (!r_mem_we) begin
                     r_rdata <= i_mem_rdata;
                  end
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_ack    <= r_gnt;
                  r_state  <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               r_gnt   <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_gnt       = r_gnt;
   assign o_ack       = r_ack;
   assign o_err       = r_err;
   assign o_rdata     = r_rdata;
   assign o_busy      = r_busy;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-timeline model checked every cycle on
// instance A (MEM_LAT=2), plus directed literal checks on A and on a MEM_LAT=1
// instance B.
module tb_mem_bus_arbiter;

   localparam int LAT = 2;
   localparam logic [31:0] LIMIT = 32'h20008C78;

   logic        clk = 1'b0;
   logic        reset;

   // Instance A (MEM_LAT = 2)
   logic [2:0]  req_a, we_a;
   logic [95:0] addr_a, wdata_a;
   logic [31:0] mrd_a;
   logic [2:0]  gnt_a, ack_a;
   logic        err_a, busy_a, en_a, mwe_a;
   logic [31:0] rdata_a, maddr_a, mwd_a;

   // Instance B (MEM_LAT = 1)
   logic [2:0]  req_b, we_b;
   logic [95:0] addr_b, wdata_b;
   logic [31:0] mrd_b;
   logic [2:0]  gnt_b, ack_b;
   logic        err_b, busy_b, en_b, mwe_b;
   logic [31:0] rdata_b, maddr_b, mwd_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STACK_LIMIT(LIMIT)) dut_a (
      .clk(clk), .reset(reset), .i_req(req_a), .i_we(we_a), .i_addr(addr_a), .i_wdata(wdata_a),
      .o_gnt(gnt_a), .o_ack(ack_a), .o_err(err_a), .o_rdata(rdata_a), .o_busy(busy_a),
      .o_mem_en(en_a), .o_mem_we(mwe_a), .o_mem_addr(maddr_a), .o_mem_wdata(mwd_a),
      .i_mem_rdata(mrd_a)
   );

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STACK_LIMIT(LIMIT)) dut_b (
      .clk(clk), .reset(reset), .i_req(req_b), .i_we(we_b), .i_addr(addr_b), .i_wdata(wdata_b),
      .o_gnt(gnt_b), .o_ack(ack_b), .o_err(err_b), .o_rdata(rdata_b), .o_busy(busy_b),
      .o_mem_en(en_b), .o_mem_we(mwe_b), .o_mem_addr(maddr_b), .o_mem_wdata(mwd_b),
      .i_mem_rdata(mrd_b)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [2:0] oh);
      case (oh)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -1;
      endcase
   endfunction

   // ---------------- Behavioural model of instance A ----------------
   // A transaction granted at edge e0 occupies the bus for LAT cycles of
   // memory access followed by one response cycle (or just the response
   // cycle if refused); the bus is free again one cycle after that.
   int          e = 0;
   int          m_e0 = 0;
   int          m_win = 0;
   int          m_ptr = 2;
   bit          m_act = 1'b0;
   bit          m_err = 1'b0;
   bit          m_we = 1'b0;
   logic [31:0] m_addr = '0, m_wd = '0, m_rd = '0;

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_act = 1'b0;
            m_ptr = 2;
            m_rd  = '0;
         end else begin
            e++;
            if (!m_act) begin
               if (req_a != 3'b000) begin
                  for (int k = 1; k <= 3; k++) begin
                     int c;
                     c = (m_ptr + k) % 3;
                     if (req_a[c]) begin
                        m_win = c;
                        break;
                     end
                  end
                  m_ptr  = m_win;
                  m_e0   = e;
                  m_act  = 1'b1;
                  m_we   = we_a[m_win];
                  m_addr = addr_a[m_win*32 +: 32];
                  m_wd   = wdata_a[m_win*32 +: 32];
                  m_err  = (m_win == 2) && m_we && (m_addr == LIMIT);
               end
            end else begin
               if (!m_err && !m_we && e == m_e0 + LAT) m_rd = mrd_a;
               if (e == m_e0 + (m_err ? 1 : LAT + 1)) m_act = 1'b0;
            end
         end
      end
   end

   // ---------------- Per-cycle compare against the model ----------------
   initial begin
      forever begin
         logic [2:0] x_gnt, x_ack;
         logic       x_err, x_busy, x_en, x_we;
         int         k;
         @(negedge clk);
         x_gnt = '0; x_ack = '0; x_err = 1'b0; x_busy = 1'b0; x_en = 1'b0; x_we = 1'b0;
         if (m_act && !reset) begin
            k      = e - m_e0;
            x_busy = 1'b1;
            x_gnt  = 3'b001 << m_win;
            if (m_err) begin
               x_ack = x_gnt;
               x_err = 1'b1;
            end else if (k < LAT) begin
               x_en = 1'b1;
               x_we = m_we;
            end else begin
               x_ack = x_gnt;
            end
         end
         chk("gnt", gnt_a, x_gnt);
         chk("ack", ack_a, x_ack);
         chk("err", err_a, x_err);
         chk("busy", busy_a, x_busy);
         chk("mem_en", en_a, x_en);
         chk("mem_we", mwe_a, x_we);
         chk("rdata", rdata_a, m_rd);
         if (x_en) begin
            chk("mem_addr", maddr_a, m_addr);
            if (x_we) chk("mem_wdata", mwd_a, m_wd);
         end
      end
   end

   // ---------------- Stimulus helpers ----------------
   task automatic set_port(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
      we_a[p]           = w;
      addr_a[p*32 +: 32]  = a;
      wdata_a[p*32 +: 32] = d;
   endtask

   task automatic wait_ack(input int budget, input bit drop, output int n, output int en_cnt,
                           output logic [31:0] last_wd, output logic [31:0] last_addr,
                           output logic [2:0] ackv, output logic errv);
      bit done;
      done = 1'b0; n = 0; en_cnt = 0; ackv = '0; errv = 1'b0;
      last_wd = '0; last_addr = '0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         if (en_a) begin
            en_cnt++;
            last_addr = maddr_a;
            if (mwe_a) last_wd = mwd_a;
         end
         if (ack_a != 3'b000) begin
            ackv = ack_a;
            errv = err_a;
            done = 1'b1;
            if (drop) req_a = 3'b000;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout got no ack within %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- Directed tests ----------------
   initial begin
      int          n, en_cnt, gap, last_ack, nacks;
      logic [31:0] lwd, laddr, prev;
      logic [2:0]  av;
      logic        ev;
      int          got_ord[6];
      int          exp_ord[6];

      exp_ord = '{0, 1, 2, 0, 1, 2};
      reset = 1'b1;
      req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; mrd_a = '0;
      req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; mrd_b = '0;
      #1;
      chk("rst_gnt", gnt_a, 3'b000);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_rdata", rdata_a, 32'h0);
      chk("rst_mem_addr", maddr_a, 32'h0);
      chk("rst_mem_en", en_a, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: single fetch read
      @(negedge clk);
      set_port(0, 1'b0, 32'h100, 32'h0);
      mrd_a = 32'hDEADBEEF;
      req_a = 3'b001;
      wait_ack(10, 1'b1, n, en_cnt, lwd, laddr, av, ev);
      chk("t1_latency", n, 3);
      chk("t1_en_cycles", en_cnt, 2);
      chk("t1_mem_addr", laddr, 32'h100);
      chk("t1_ack", av, 3'b001);
      chk("t1_rdata", rdata_a, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_busy_low", busy_a, 1'b0);

      // 2: all three requesting continuously -> strict rotation
      do_reset();
      set_port(0, 1'b0, 32'h200, 32'h0);
      set_port(1, 1'b0, 32'h300, 32'h0);
      set_port(2, 1'b0, 32'h400, 32'h0);
      mrd_a = 32'hA5A5_0001;
      req_a = 3'b111;
      for (int i = 0; i < 6; i++) begin
         wait_ack(20, (i == 5), n, en_cnt, lwd, laddr, av, ev);
         got_ord[i] = idx_of(av);
      end
      for (int i = 0; i < 6; i++) chk("t2_rr_order", got_ord[i], exp_ord[i]);

      // 3: refused stack write, then a normal stack write just below the limit
      @(negedge clk);
      set_port(2, 1'b1, LIMIT, 32'h1111_2222);
      req_a = 3'b100;
      wait_ack(10, 1'b1, n, en_cnt, lwd, laddr, av, ev);
      chk("t3_refuse_latency", n, 1);
      chk("t3_refuse_no_en", en_cnt, 0);
      chk("t3_refuse_ack", av, 3'b100);
      chk("t3_refuse_err", ev, 1'b1);
      @(negedge clk);
      set_port(2, 1'b1, 32'h20008C74, 32'hCAFEF00D);
      req_a = 3'b100;
      wait_ack(10, 1'b1, n, en_cnt, lwd, laddr, av, ev);
      chk("t3_ok_en_cycles", en_cnt, 2);
      chk("t3_ok_wdata", lwd, 32'hCAFEF00D);
      chk("t3_ok_ack", av, 3'b100);
      chk("t3_ok_err", ev, 1'b0);
      we_a = '0;

      // 4: inputs changed and req dropped after grant
      @(negedge clk);
      set_port(1, 1'b1, 32'h2000, 32'h12345678);
      req_a = 3'b010;
      n = 0;
      while (!en_a && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t4_first_wdata", mwd_a, 32'h12345678);
      wdata_a[32 +: 32] = 32'h0BADF00D;
      req_a = 3'b000;
      wait_ack(10, 1'b0, n, en_cnt, lwd, laddr, av, ev);
      chk("t4_en_rest", en_cnt, 1);
      chk("t4_wdata_held", lwd, 32'h12345678);
      chk("t4_ack", av, 3'b010);
      we_a = '0;

      // 5: reset during the second access cycle of a data read
      @(negedge clk);
      set_port(1, 1'b0, 32'h3000, 32'h0);
      mrd_a = 32'h55AA55AA;
      req_a = 3'b010;
      n = 0;
      while (!en_a && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_en_async", en_a, 1'b0);
      chk("t5_gnt_async", gnt_a, 3'b000);
      chk("t5_busy_async", busy_a, 1'b0);
      chk("t5_no_ack", ack_a, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      set_port(0, 1'b0, 32'h500, 32'h0);
      req_a = 3'b011;
      wait_ack(10, 1'b1, n, en_cnt, lwd, laddr, av, ev);
      chk("t5_fetch_first", av, 3'b001);

      // 6: MEM_LAT=1 back-to-back fetch reads on instance B
      @(negedge clk);
      mrd_b = 32'h1111_0000;
      req_b = 3'b001;
      last_ack = -1; nacks = 0; prev = '0;
      for (int i = 0; i < 30 && nacks < 4; i++) begin
         @(negedge clk);
         if (ack_b != 3'b000) begin
            if (last_ack >= 0) begin
               gap = i - last_ack;
               chk("t6_ack_gap", gap, 3);
            end
            chk("t6_rdata", rdata_b, mrd_b);
            prev     = mrd_b;
            last_ack = i;
            nacks++;
            mrd_b = mrd_b + 32'h0000_1111;
         end else if (nacks > 0) begin
            chk("t6_rdata_hold", rdata_b, prev);
         end
      end
      req_b = 3'b000;
      chk("t6_ack_count", nacks, 4);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
